uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/arch_defs_pkg.sv | 13 +
 rtl/loader_pkg.sv | 27 ++
 rtl/uart_loader.sv | 171 +++++++++++++++++
 tb/tb_uart_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: shared architecture constants and the UART peripheral register map.
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        UART_REG_DATA   = 2'd0,
        UART_REG_STATUS = 2'd1,
        UART_REG_CTRL   = 2'd2,
        UART_REG_BAUD   = 2'd3
    } uart_reg_offset_e;

endpackage

// File: rtl/loader_pkg.sv
// loader_pkg: FSM states, frame phases and protocol bytes of the UART boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL_RX,
        ST_READ_RX,
        ST_WRITE_MEM,
        ST_POLL_TX,
        ST_SEND_RESP,
        ST_FINISH
    } loader_state_e;

    typedef enum logic [2:0] {
        PH_SYNC,
        PH_ADDR_HI,
        PH_ADDR_LO,
        PH_LEN,
        PH_DATA,
        PH_CSUM
    } loader_phase_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/uart_loader.sv
// uart_loader: polls a UART for a framed image, writes it to memory and answers ACK/NAK.
// Owns the peripheral bus while busy; bus_data_in is sampled in the same cycle as the read.
module uart_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH     = arch_defs_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    output arch_defs_pkg::uart_reg_offset_e bus_addr_offset,
    output logic                            bus_enable,
    output logic                            bus_read,
    output logic                            bus_write,
    output logic [DATA_WIDTH-1:0]           bus_data_out,
    input  logic [DATA_WIDTH-1:0]           bus_data_in,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_data,
    output logic                            mem_we,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_e         state_q, state_d;
    loader_phase_e         phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic rx_flag_err, rx_ok, rx_bad, timeout;

    // Line-error flags only matter once a frame is underway; while hunting for SYNC they are read through.
    assign rx_flag_err = bus_data_in[2] | bus_data_in[3];
    assign rx_ok       = bus_data_in[1] & ((phase_q == PH_SYNC) | ~rx_flag_err);
    assign rx_bad      = (phase_q != PH_SYNC) & rx_flag_err;
    assign timeout     = (phase_q != PH_SYNC) & (tmo_q >= TW'(TIMEOUT_CYCLES - 1));

    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign busy     = (state_q != ST_IDLE) & (state_q != ST_FINISH);
    assign done     = state_q == ST_FINISH;
    assign error    = err_q;

    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        addr_d          = addr_q;
        len_d           = len_q;
        csum_d          = csum_q;
        data_d          = data_q;
        resp_d          = resp_q;
        err_d           = err_q;
        tmo_d           = (state_q == ST_IDLE || phase_q == PH_SYNC) ? '0 : tmo_q + TW'(1);
        bus_addr_offset = arch_defs_pkg::UART_REG_DATA;
        bus_enable      = 1'b0;
        bus_read        = 1'b0;
        bus_write       = 1'b0;
        bus_data_out    = '0;
        mem_we          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_POLL_RX;
                    phase_d = PH_SYNC;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    len_d   = '0;
                    csum_d  = '0;
                end
            end
            ST_POLL_RX: begin
                bus_enable      = 1'b1;
                bus_read        = 1'b1;
                bus_addr_offset = arch_defs_pkg::UART_REG_STATUS;
                if (rx_ok) begin
                    state_d = ST_READ_RX;
                end else if (rx_bad || timeout) begin
                    state_d = ST_POLL_TX;
                    resp_d  = DATA_WIDTH'(NAK_BYTE);
                    err_d   = 1'b1;
                end
            end
            ST_READ_RX: begin
                bus_enable = 1'b1;
                bus_read   = 1'b1;
                tmo_d      = '0;
                state_d    = ST_POLL_RX;
                case (phase_q)
                    PH_SYNC:    phase_d = (bus_data_in == DATA_WIDTH'(SYNC_BYTE)) ? PH_ADDR_HI : PH_SYNC;
                    PH_ADDR_HI: begin
                        addr_d  = ADDR_WIDTH'(bus_data_in) << DATA_WIDTH;
                        phase_d = PH_ADDR_LO;
                    end
                    PH_ADDR_LO: begin
                        addr_d  = addr_q | ADDR_WIDTH'(bus_data_in);
                        phase_d = PH_LEN;
                    end
                    PH_LEN: begin
                        len_d   = (bus_data_in == '0) ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, bus_data_in};
                        csum_d  = '0;
                        phase_d = PH_DATA;
                    end
                    PH_DATA: begin
                        data_d  = bus_data_in;
                        state_d = ST_WRITE_MEM;
                    end
                    default: begin
                        resp_d  = (bus_data_in == csum_q) ? DATA_WIDTH'(ACK_BYTE) : DATA_WIDTH'(NAK_BYTE);
                        err_d   = err_q | (bus_data_in != csum_q);
                        state_d = ST_POLL_TX;
                    end
                endcase
            end
            ST_WRITE_MEM: begin
                mem_we  = 1'b1;
                addr_d  = addr_q + ADDR_WIDTH'(1);
                csum_d  = csum_q + data_q;
                len_d   = len_q - (DATA_WIDTH + 1)'(1);
                phase_d = (len_q == (DATA_WIDTH + 1)'(1)) ? PH_CSUM : PH_DATA;
                state_d = ST_POLL_RX;
            end
            ST_POLL_TX: begin
                bus_enable      = 1'b1;
                bus_read        = 1'b1;
                bus_addr_offset = arch_defs_pkg::UART_REG_STATUS;
                state_d         = bus_data_in[0] ? ST_SEND_RESP : ST_POLL_TX;
            end
            ST_SEND_RESP: begin
                bus_enable   = 1'b1;
                bus_write    = 1'b1;
                bus_data_out = resp_q;
                state_d      = ST_FINISH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_SYNC;
            addr_q  <= '0;
            len_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames against a small UART host model, with immediate-assertion checks.
module tb_uart_loader;
    import arch_defs_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    uart_reg_offset_e bus_addr_offset;
    logic             bus_enable, bus_read, bus_write, mem_we, busy, done, error;
    logic [7:0]       bus_data_out, bus_data_in, mem_data;
    logic [15:0]      mem_addr;

    uart_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .bus_addr_offset(bus_addr_offset), .bus_enable(bus_enable), .bus_read(bus_read),
        .bus_write(bus_write), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Host-side UART: receive FIFO filled by the stimulus, popped by DATA reads.
    logic [7:0] rx_buf [0:1023];
    int wr_ptr = 0, rd_ptr = 0, inj_idx = -1, tx_ready_cyc = 0, cyc = 0;
    logic rx_avail;
    assign rx_avail = rd_ptr != wr_ptr;
    assign bus_data_in = (bus_addr_offset == UART_REG_STATUS)
        ? {5'b0, rx_avail && (rd_ptr == inj_idx), rx_avail, cyc >= tx_ready_cyc}
        : rx_buf[rd_ptr[9:0]];

    always @(posedge clk)
        if (bus_enable && bus_read && bus_addr_offset == UART_REG_DATA) rd_ptr <= rd_ptr + 1;

    logic [15:0] wa [0:1023];
    logic [7:0]  wd [0:1023];
    int wr_cnt = 0, tx_cnt = 0, done_cnt = 0, tx_cyc = 0, rd_cyc = 0;
    logic [7:0] tx_last = 8'h00;
    logic rw_bad = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            wa[wr_cnt[9:0]] <= mem_addr;
            wd[wr_cnt[9:0]] <= mem_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus_enable && bus_write) begin
            tx_last <= bus_data_out;
            tx_cnt  <= tx_cnt + 1;
            tx_cyc  <= cyc;
        end
        if (bus_enable && bus_read && bus_addr_offset == UART_REG_DATA) rd_cyc <= cyc;
        if (done) done_cnt <= done_cnt + 1;
        if (bus_read && bus_write) rw_bad <= 1'b1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf[wr_ptr[9:0]] = b;
        wr_ptr++;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_done"}, done_cnt - d0, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic frame3(input logic [7:0] hi, input logic [7:0] cs);
        push(8'hA5); push(hi); push(8'h00); push(8'h03);
        push(8'h11); push(8'h22); push(8'h33); push(cs);
    endtask

    int w0, t0, n;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_bus", {bus_enable, bus_read, bus_write, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        reset_n = 1'b1;

        // Good frame at 0x1234 with a late TX-empty and a start pulse while busy.
        tx_ready_cyc = cyc + 40;
        w0 = wr_cnt; t0 = tx_cnt;
        push(8'hA5); push(8'h12); push(8'h34); push(8'h03);
        push(8'h11); push(8'h22); push(8'h33); push(8'h66);
        pulse_start();
        chk("a_busy", busy, 1);
        pulse_start();
        wait_done(300, "a");
        chk("a_nwr", wr_cnt - w0, 3);
        chk("a_w0", {wa[w0], wd[w0]}, {16'h1234, 8'h11});
        chk("a_w1", {wa[w0+1], wd[w0+1]}, {16'h1235, 8'h22});
        chk("a_w2", {wa[w0+2], wd[w0+2]}, {16'h1236, 8'h33});
        chk("a_ntx", tx_cnt - t0, 1);
        chk("a_tx", tx_last, 8'h06);
        chk("a_txwait", tx_cyc >= tx_ready_cyc, 1);
        chk("a_err", error, 0);
        chk("a_idle", busy, 0);

        // Bad checksum: writes still land, NAK, sticky error.
        tx_ready_cyc = 0;
        w0 = wr_cnt; t0 = tx_cnt;
        push(8'hA5); push(8'h12); push(8'h34); push(8'h03);
        push(8'h11); push(8'h22); push(8'h33); push(8'h67);
        pulse_start();
        wait_done(300, "b");
        chk("b_nwr", wr_cnt - w0, 3);
        chk("b_w2", {wa[w0+2], wd[w0+2]}, {16'h1236, 8'h33});
        chk("b_tx", tx_last, 8'h15);
        repeat (5) @(negedge clk);
        #1;
        chk("b_err", error, 1);

        // Leading garbage, then a frame wrapping 0xFFFF -> 0x0000.
        w0 = wr_cnt; t0 = tx_cnt;
        push(8'h00); push(8'hFF);
        push(8'hA5); push(8'hFF); push(8'hFF); push(8'h02);
        push(8'hAA); push(8'hBB); push(8'h65);
        pulse_start();
        chk("c_errclr", error, 0);
        wait_done(300, "c");
        chk("c_nwr", wr_cnt - w0, 2);
        chk("c_w0", {wa[w0], wd[w0]}, {16'hFFFF, 8'hAA});
        chk("c_w1", {wa[w0+1], wd[w0+1]}, {16'h0000, 8'hBB});
        chk("c_tx", tx_last, 8'h06);

        // LEN=0 means 256 bytes; data i = i, sum = 0x80.
        w0 = wr_cnt;
        push(8'hA5); push(8'h40); push(8'h00); push(8'h00);
        for (int i = 0; i < 256; i++) push(i[7:0]);
        push(8'h80);
        pulse_start();
        wait_done(2000, "d");
        chk("d_nwr", wr_cnt - w0, 256);
        chk("d_first", {wa[w0], wd[w0]}, {16'h4000, 8'h00});
        chk("d_last", {wa[w0+255], wd[w0+255]}, {16'h40FF, 8'hFF});
        chk("d_tx", tx_last, 8'h06);
        chk("d_err", error, 0);

        // Frame error flagged on data byte index 10: NAK, only 10 writes.
        flush();
        w0 = wr_cnt;
        inj_idx = rd_ptr + 14;
        push(8'hA5); push(8'h50); push(8'h00); push(8'h00);
        for (int i = 0; i < 256; i++) push(i[7:0]);
        push(8'h80);
        pulse_start();
        wait_done(2000, "e");
        chk("e_nwr", wr_cnt - w0, 10);
        chk("e_last", {wa[w0+9], wd[w0+9]}, {16'h5009, 8'h09});
        chk("e_tx", tx_last, 8'h15);
        chk("e_err", error, 1);
        flush();
        inj_idx = -1;

        // Host stalls after ADDR_LO: 100 idle polls, then POLL_TX and SEND_RESP -> 102 cycles after the read.
        w0 = wr_cnt;
        push(8'hA5); push(8'h12); push(8'h34);
        pulse_start();
        wait_done(400, "f");
        chk("f_nwr", wr_cnt - w0, 0);
        chk("f_tx", tx_last, 8'h15);
        chk("f_err", error, 1);
        chk("f_delay", tx_cyc - rd_cyc, 102);

        // Asynchronous reset in the middle of the data bytes.
        w0 = wr_cnt;
        push(8'hA5); push(8'h60); push(8'h00); push(8'h08);
        for (int i = 0; i < 8; i++) push(8'h30 + i[7:0]);
        push(8'h00);
        pulse_start();
        n = 0;
        while (wr_cnt - w0 < 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("g_progress", wr_cnt - w0 >= 3, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("g_busy", busy, 0);
        chk("g_bus", {bus_enable, bus_read, bus_write, mem_we, done}, 0);
        chk("g_mem", {mem_addr, mem_data}, 0);
        chk("g_err", error, 0);
        t0 = tx_cnt;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("g_notx", tx_cnt - t0, 0);
        chk("g_idle", busy, 0);
        flush();
        w0 = wr_cnt;
        frame3(8'h70, 8'h66);
        pulse_start();
        wait_done(300, "g");
        chk("g_nwr", wr_cnt - w0, 3);
        chk("g_w0", {wa[w0], wd[w0]}, {16'h7000, 8'h11});
        chk("g_w2", {wa[w0+2], wd[w0+2]}, {16'h7002, 8'h33});
        chk("g_tx", tx_last, 8'h06);

        chk("rw_excl", rw_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
